// File: rtl/if_stage.sv
// if_stage: instruction fetch with a stall hold buffer and a one-delay-slot branch redirect.
// Optional macro IF_ADEL_EN adds misaligned-fetch error reporting through an ERR state.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_adel
);

  localparam int unsigned AW = 32;

`ifdef IF_ADEL_EN
  typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_ERR = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;
`endif

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   pc;
  logic            pend_valid;
  logic [AW-1:0]   pend_target;
  logic [AW-1:0]   hold_pc;
  logic [AW-1:0]   hold_inst;
  logic            fetch_ok;
  logic            fetch_done;
  logic [AW-1:0]   next_pc_fetch;

  // Without error reporting, every address entering the PC is word-aligned.
  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
`ifdef IF_ADEL_EN
    return a;
`else
    return a & {{(AW-2){1'b1}}, 2'b00};
`endif
  endfunction

`ifdef IF_ADEL_EN
  logic misaligned;
  assign misaligned = (pc[1:0] != 2'b00);
  assign fetch_ok   = (state == S_REQ) && !misaligned;
`else
  assign fetch_ok   = (state == S_REQ);
`endif

  assign fetch_done = fetch_ok && inst_ack;

  // A same-cycle branch wins over an older pending one; the in-flight word is the delay slot.
  assign next_pc_fetch = branch_flag ? align(branch_target_addr) :
                         pend_valid  ? pend_target :
                                       pc + AW'(4);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_REQ: begin
        if (fetch_done && stall) state_next = S_HOLD;
`ifdef IF_ADEL_EN
        if (misaligned && !stall) state_next = S_ERR;
`endif
      end
      S_HOLD: if (!stall) state_next = S_REQ;
`ifdef IF_ADEL_EN
      S_ERR: if (branch_flag || pend_valid) state_next = S_REQ;
`endif
      default: state_next = S_REQ;
    endcase
  end

  // Memory-facing outputs; the request is withheld while reset is high
  always_comb begin
    inst_req  = 1'b0;
    inst_addr = pc;
    if (!rst && fetch_ok) inst_req = 1'b1;
  end

  // PC, branch bookkeeping, hold buffer and IF/ID outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= align(RESET_PC);
      pend_valid  <= 1'b0;
      pend_target <= '0;
      hold_pc     <= '0;
      hold_inst   <= '0;
      if_pc       <= '0;
      if_inst     <= '0;
      if_valid    <= 1'b0;
`ifdef IF_ADEL_EN
      if_adel     <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (fetch_done) begin
            pc         <= next_pc_fetch;
            pend_valid <= 1'b0;
            if (stall) begin
              hold_pc   <= pc;
              hold_inst <= inst_rdata;
            end else begin
              if_pc    <= pc;
              if_inst  <= inst_rdata;
              if_valid <= 1'b1;
`ifdef IF_ADEL_EN
              if_adel  <= 1'b0;
`endif
            end
          end else begin
            if (branch_flag) begin
              pend_valid  <= 1'b1;
              pend_target <= align(branch_target_addr);
            end
            if (!stall) begin
`ifdef IF_ADEL_EN
              if (misaligned) begin
                if_pc    <= pc;
                if_inst  <= '0;
                if_valid <= 1'b1;
                if_adel  <= 1'b1;
              end else begin
                if_valid <= 1'b0;
                if_adel  <= 1'b0;
              end
`else
              if_valid <= 1'b0;
`endif
            end
          end
        end
        S_HOLD: begin
          // PC is idle here, so a late branch can retarget the next fetch directly
          if (branch_flag) pc <= align(branch_target_addr);
          if (!stall) begin
            if_pc    <= hold_pc;
            if_inst  <= hold_inst;
            if_valid <= 1'b1;
`ifdef IF_ADEL_EN
            if_adel  <= 1'b0;
`endif
          end
        end
`ifdef IF_ADEL_EN
        S_ERR: begin
          if (branch_flag) begin
            pc         <= branch_target_addr;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            pc         <= pend_target;
            pend_valid <= 1'b0;
          end
          if (!stall) if_valid <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef IF_ADEL_EN
  assign if_adel = 1'b0;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port stall, input, 1 bit: pipeline hold from control; when high, the IF/ID-facing outputs SHALL not change.
REQ-005 The block SHALL have port branch_flag, input, 1 bit: single-cycle redirect request from ID.
REQ-006 The block SHALL have port branch_target_addr, input, 32 bits: redirect address, sampled when branch_flag is high.
REQ-007 The block SHALL have port inst_req, output, 1 bit: instruction-memory read request.
REQ-008 The block SHALL have port inst_addr, output, 32 bits: instruction-memory read address.
REQ-009 The block SHALL have port inst_ack, input, 1 bit: memory returns inst_rdata this cycle; it is meaningful only while inst_req is high.
REQ-010 The block SHALL have port inst_rdata, input, 32 bits: fetched instruction word.
REQ-011 The block SHALL have port if_pc, output, 32 bits, registered: PC of the presented instruction.
REQ-012 The block SHALL have port if_inst, output, 32 bits, registered: presented instruction word.
REQ-013 The block SHALL have port if_valid, output, 1 bit, registered: if_pc/if_inst hold a real instruction; low means bubble.
REQ-014 The block SHALL have port if_adel, output, 1 bit, registered: fetch address error flag (see Configuration).

Function
REQ-015 The FSM SHALL have the states REQ (fetch outstanding), HOLD (fetched word buffered while stalled) and ERR (misaligned PC, configured builds only).
REQ-016 In REQ, the block SHALL drive inst_req=1 and inst_addr=pc; inst_addr SHALL stay constant until inst_ack arrives.
REQ-017 On REQ with inst_ack=1 and stall=0, the block SHALL set if_inst<=inst_rdata, if_pc<=pc and if_valid<=1 at the next edge, and SHALL stay in REQ with the next pc.
REQ-018 On REQ with inst_ack=0 and stall=0, the block SHALL set if_valid<=0 as a bubble; if_pc and if_inst may hold.
REQ-019 On REQ with inst_ack=1 and stall=1, the block SHALL capture inst_rdata and pc into a hold buffer, enter HOLD, and leave the outputs unchanged.
REQ-020 In HOLD, the block SHALL drive inst_req=0; on the first cycle with stall=0 it SHALL move the buffer to the outputs (if_valid<=1) and return to REQ.
REQ-021 The next pc SHALL be pc+4 with 32-bit wrap (32'hFFFF_FFFC -> 0), unless a branch is pending.
REQ-022 branch_flag SHALL set pending_target<=branch_target_addr; a second branch_flag before it is consumed SHALL overwrite the target.
REQ-023 The block SHALL consume a pending branch at the first completed fetch (REQ with inst_ack=1), setting next pc = target; if branch_flag and inst_ack occur in the same cycle, target SHALL be used directly, so the in-flight fetch is the delay slot.
REQ-024 branch_flag arriving in HOLD SHALL be recorded; the buffered word is the delay slot and the next fetch is the target.
REQ-025 stall=1 in REQ with no ack SHALL keep the request outstanding; it SHALL not be withdrawn.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set pc=RESET_PC, state=REQ, branch pending cleared, if_pc=0, if_inst=0, if_valid=0, if_adel=0, and discard the hold buffer.
REQ-027 While rst is high, the block SHALL drive inst_req=0; the first request SHALL be issued in the cycle after rst falls.
REQ-028 Reset asserted mid-fetch SHALL drop the request; a late inst_ack SHALL be ignored.

Configuration
REQ-029 With macro IF_ADEL_EN defined, a pc with pc[1:0]!=0 on entering REQ SHALL go to ERR, issue no request, and present if_valid=1, if_inst=0, if_adel=1, if_pc=pc once (respecting stall); ERR SHALL exit only via branch_flag to the new target.
REQ-030 Without IF_ADEL_EN, the block SHALL force fetch addresses to {addr[31:2],2'b00}, tie if_adel to 0, and omit ERR.

Verification
REQ-031 Reset then ack every cycle: inst_addr SHALL be 0, 4, 8; if_pc SHALL follow one cycle later, with if_valid=1 continuously.
REQ-032 Ack delayed 3 cycles at addr 8: inst_req and inst_addr=8 SHALL hold; if_valid=0 for those cycles, then if_pc=8.
REQ-033 stall=1 coincident with ack of addr 0x10 (rdata 0xDEADBEEF): outputs SHALL freeze and inst_req=0; after stall falls, if_pc=0x10 and if_inst=0xDEADBEEF.
REQ-034 branch_flag with target 0x100 while fetching 0x20 (acked same cycle): 0x20 SHALL be presented, then the next inst_addr=0x100; two branches 0x100 then 0x200 before ack SHALL fetch 0x200.
REQ-035 With IF_ADEL_EN, branch to 0x102: if_adel=1, if_inst=0 and no inst_req until branch to 0x200; without the macro, the fetch address SHALL be 0x100.
